// File: rtl/adc_lt2389_emulator_if.sv
// Pin-level bundle between an LTC2389-24 read master and the ADC side (real part or emulator).
// Signal names keep the ADC-side direction prefixes so both ends read the same.
interface adc_lt2389_emulator_if;
    logic i_cnv;
    logic i_sck;
    logic i_rdl_sdi;
    logic o_busy;
    logic o_sdo;
    logic o_sdo_oe;

    modport master (output i_cnv, i_sck, i_rdl_sdi, input o_busy, o_sdo, o_sdo_oe);
    modport slave  (input i_cnv, i_sck, i_rdl_sdi, output o_busy, o_sdo, o_sdo_oe);
endinterface

// File: rtl/adc_lt2389_emulator.sv
// ADC-side responder for the LTC2389-24 CNV/BUSY/SCK/SDO read protocol.
// Latches a local sample word on CNV, models BUSY, then shifts the word out MSB first on SCK.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for CNV; SDO parked low
//   CONVERT | BUSY high, down-counting the modelled conversion time
//   SHIFT   | SCK rise counts a bit sampled by the master, SCK fall shifts
module adc_lt2389_emulator #(
    parameter int DATA_WIDTH  = 24,
    parameter int CONV_CYCLES = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  i_reset,
    adc_lt2389_emulator_if.slave  adc,
    input  logic [DATA_WIDTH-1:0] i_sample_data,
    input  logic                  i_sample_valid,
    output logic                  o_sample_ack,
    output logic                  o_frame_done,
    output logic                  o_err_cnv_busy,
    output logic                  o_err_truncated
);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int BUSY_W = $clog2(CONV_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, SHIFT = 2'd2} state_t;

    state_t                  state, state_d;
    logic [SYNC_STAGES-1:0]  cnv_sync, sck_sync, rdl_sync;
    logic                    cnv_hist, sck_hist;
    logic                    cnv_rise, sck_rise, sck_fall, rdl_q;
    logic [DATA_WIDTH-1:0]   word_q, shift_q;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BUSY_W-1:0]       busy_cnt;
    logic                    sdo_q, sdo_oe_q;
    logic                    load, ack_d, err_busy_d, err_trunc_d, conv_done, shift_en, done_d;

    // Edge pulses are registered once more so every pin event lands SYNC_STAGES+1 cycles later.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnv_sync <= '0;
            sck_sync <= '0;
            rdl_sync <= '0;
            cnv_hist <= 1'b0;
            sck_hist <= 1'b0;
            cnv_rise <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            rdl_q    <= 1'b0;
        end else begin
            cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], adc.i_cnv};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], adc.i_sck};
            rdl_sync <= {rdl_sync[SYNC_STAGES-2:0], adc.i_rdl_sdi};
            cnv_hist <= cnv_sync[SYNC_STAGES-1];
            sck_hist <= sck_sync[SYNC_STAGES-1];
            cnv_rise <= cnv_sync[SYNC_STAGES-1] & ~cnv_hist;
            sck_rise <= sck_sync[SYNC_STAGES-1] & ~sck_hist;
            sck_fall <= ~sck_sync[SYNC_STAGES-1] & sck_hist;
            rdl_q    <= rdl_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (cnv_rise) state_d = CONVERT;
            CONVERT: if (conv_done) state_d = SHIFT;
            SHIFT: begin
                if (cnv_rise)    state_d = CONVERT;
                else if (done_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A CNV edge always beats an SCK edge in the same cycle; RDL_SDI freezes readout only.
    always_comb begin
        load         = cnv_rise && (state != CONVERT);
        ack_d        = load && i_sample_valid;
        err_busy_d   = cnv_rise && (state == CONVERT);
        err_trunc_d  = cnv_rise && (state == SHIFT);
        conv_done    = (state == CONVERT) && (busy_cnt == '0);
        shift_en     = (state == SHIFT) && !cnv_rise && !rdl_q;
        done_d       = shift_en && sck_rise && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
        adc.o_busy   = (state == CONVERT);
        adc.o_sdo    = sdo_q & sdo_oe_q;
        adc.o_sdo_oe = sdo_oe_q;
    end

    // word_q keeps the last accepted sample so a CNV without a fresh word replays it intact.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            word_q          <= '0;
            shift_q         <= '0;
            bit_cnt         <= '0;
            busy_cnt        <= '0;
            sdo_q           <= 1'b0;
            sdo_oe_q        <= 1'b0;
            o_sample_ack    <= 1'b0;
            o_frame_done    <= 1'b0;
            o_err_cnv_busy  <= 1'b0;
            o_err_truncated <= 1'b0;
        end else begin
            o_sample_ack    <= ack_d;
            o_frame_done    <= done_d;
            o_err_cnv_busy  <= err_busy_d;
            o_err_truncated <= err_trunc_d;
            sdo_oe_q        <= ~rdl_q;
            if (load) begin
                if (i_sample_valid) begin
                    word_q  <= i_sample_data;
                    shift_q <= i_sample_data;
                end else begin
                    shift_q <= word_q;
                end
                busy_cnt <= BUSY_W'(CONV_CYCLES - 1);
                sdo_q    <= 1'b0;
            end else if (conv_done) begin
                sdo_q   <= shift_q[DATA_WIDTH-1];
                bit_cnt <= '0;
            end else if (state == CONVERT) begin
                busy_cnt <= busy_cnt - 1'b1;
            end else if (shift_en && sck_rise) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (done_d) sdo_q <= 1'b0;
            end else if (shift_en && sck_fall) begin
                shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                sdo_q   <= shift_q[DATA_WIDTH-2];
            end
        end
    end
endmodule

// File: doc/adc_lt2389_emulator.md
# adc_lt2389_emulator

Synthesizable responder for the LTC2389-24 serial read interface: plays the ADC side of the CNV/BUSY/SCK/SDO protocol so the ADC master interface can be exercised in simulation and in hardware-in-the-loop without the physical converter. It accepts 24-bit sample words from a local source (pattern generator, BRAM playback), starts a modelled conversion on each CNV rising edge, then shifts the word out MSB first on the master's SCK. It sits on the FPGA fabric in place of the ADC pins, wired back-to-back with the ADC master interface.

## Interface
- DATA_WIDTH, 24, sample word width (bits shifted per frame)
- CONV_CYCLES, 20, BUSY high time in clk cycles (≥2)
- SYNC_STAGES, 2, synchronizer flops on CNV/SCK/RDL_SDI (≥2)

- clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cnv  in  1  CNV from master, asynchronous to clk
- i_sck  in  1  SCK from master, asynchronous to clk
- i_rdl_sdi  in  1  RDL/SDI from master; high disables readout
- i_sample_data  in  DATA_WIDTH  next word to convert
- i_sample_valid  in  1  i_sample_data holds a fresh word
- o_sample_ack  out  1  1-cycle pulse: i_sample_data latched
- o_busy  out  1  BUSY to master
- o_sdo  out  1  SDO to master
- o_sdo_oe  out  1  SDO drive enable (low models Hi-Z)
- o_frame_done  out  1  1-cycle pulse: all DATA_WIDTH bits clocked out
- o_err_cnv_busy  out  1  1-cycle pulse: CNV edge ignored during conversion
- o_err_truncated  out  1  1-cycle pulse: new CNV arrived before frame finished

## Operation
- i_cnv, i_sck, i_rdl_sdi each pass through SYNC_STAGES flops, plus one history flop for edge detection; all control uses synchronized values only.
- FSM states: IDLE, CONVERT, SHIFT. Reset -> IDLE.
- IDLE: o_busy=0. On CNV rise: if i_sample_valid, shift register <= i_sample_data and o_sample_ack=1; else shift register keeps previous word (no ack). Load busy counter with CONV_CYCLES-1, o_busy<=1, -> CONVERT.
- CONVERT: o_busy=1, counter decrements each cycle. At counter==0: o_busy<=0, o_sdo<=shift register MSB, bit counter<=0, -> SHIFT. CNV rise here: ignored, o_err_cnv_busy pulse.
- SHIFT: each SCK rising edge increments bit counter (master samples on this edge). Each SCK falling edge shifts register left by one, zero fill; o_sdo follows new MSB. On the rising edge that makes bit counter == DATA_WIDTH: o_frame_done pulse, -> IDLE; o_sdo then held 0 until next frame.
- CNV rise in SHIFT: o_err_truncated pulse, then handled exactly as CNV rise in IDLE (new latch, -> CONVERT).
- Synchronized RDL_SDI high: o_sdo_oe=0, o_sdo=0, SCK edges ignored (no shift, no count); conversion timing and BUSY unaffected. o_sdo_oe=1 otherwise.
- Simultaneous CNV rise and SCK edge in SHIFT: CNV wins, SCK edge discarded.
- Bit counter width $clog2(DATA_WIDTH+1); busy counter width $clog2(CONV_CYCLES).

## Timing
- Reset values: o_busy=0, o_sdo=0, o_sdo_oe=0, o_sample_ack=0, o_frame_done=0, both error flags 0, shift register 0, synchronizer and history flops 0 (so CNV/SCK high at reset release is not an edge).
- Pin-to-response latency L = SYNC_STAGES+1 cycles: CNV rise sampled at edge k -> o_busy=1 and o_sample_ack=1 after edge k+L.
- o_busy high exactly CONV_CYCLES cycles; MSB on o_sdo in the same cycle o_busy falls.
- SCK fall sampled at edge k -> o_sdo updated after edge k+L.
- Master constraint: SCK high and low times each ≥ L+1 clk cycles; first SCK rise ≥ L+1 cycles after BUSY falls at the pin.
- Reset mid-frame: everything returns to reset values on the next edge; partial frame discarded, no o_frame_done.

## Test plan
- Reset, i_sample_data=24'hA5C3F0 valid, CNV rise -> o_sample_ack and o_busy high after 3 cycles, o_busy high 20 cycles, 24 SCK pulses read 24'hA5C3F0 MSB first, o_frame_done once, o_sdo=0 afterwards.
- Back-to-back frames 24'h000001, 24'hFFFFFF, 24'h800000 at 48 kHz CNV, 4 MHz SCK, clk 100 MHz -> master-captured words match exactly, no error pulses.
- CNV rise during CONVERT -> one o_err_cnv_busy pulse, BUSY width unchanged (20), data unchanged.
- CNV rise after 10 of 24 SCK pulses -> o_err_truncated pulse, new word latched, new 20-cycle BUSY, next full readout returns the new word.
- RDL_SDI high during SHIFT for 5 SCK pulses -> o_sdo_oe=0, o_sdo=0, bit count frozen; after RDL_SDI low the remaining bits resume from the frozen position.
- i_sample_valid=0 at CNV -> no o_sample_ack, previous word re-sent; i_reset asserted mid-SHIFT -> all outputs at reset values next cycle, no o_frame_done.
